game_sequencer: RTL

//  Top-level game controller for the monster-jump display datapath. Converts start/jump/duck

---
 rtl/game_pkg.sv | 36 +++
 rtl/game_sequencer_tick_divider.sv | 28 ++
 rtl/game_sequencer.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/game_pkg.sv
// Shared types and defaults for the monster-jump game controller.
package game_pkg;

  typedef enum logic [1:0] {StIdle, StRun, StOver} main_state_e;

  typedef enum logic [1:0] {PoseGround, PoseDuck, PoseAir, PoseLand} pose_e;

  typedef logic [3:0] bcd_digit_t;

  localparam int unsigned DefTickDiv   = 25_000_000;
  localparam int unsigned DefMinDiv    = 5_000_000;
  localparam int unsigned DefSpeedStep = 1_000_000;
  localparam int unsigned DefJumpTicks = 3;

  // Four-digit BCD increment with ripple carry; 9999 wraps to 0000.
  function automatic logic [15:0] bcd_inc(input logic [15:0] val);
    logic [15:0] res;
    bcd_digit_t  dig;
    logic        carry;
    res   = val;
    carry = 1'b1;
    for (int i = 0; i < 4; i++) begin
      dig = res[4*i +: 4];
      if (carry) begin
        if (dig == 4'd9) begin
          res[4*i +: 4] = 4'd0;
        end else begin
          res[4*i +: 4] = dig + 4'd1;
          carry         = 1'b0;
        end
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/game_sequencer_tick_divider.sv
// Scroll-rate divider: counts 0..period-1 while enabled and flags the wrap cycle.
module tick_divider #(
  parameter int unsigned Width = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic [Width-1:0] period,
  output logic             tick
);

  logic [Width-1:0] cnt_q;

  // >= keeps the counter safe if the period shrinks under it.
  assign tick = en & ~clr & (cnt_q >= period - Width'(1));

  always_ff @(posedge clk) begin
    if (rst || clr || !en) begin
      cnt_q <= '0;
    end else if (tick) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + Width'(1);
    end
  end

endmodule

// File: rtl/game_sequencer.sv
// Game controller: start/over FSM, jump/duck pose FSM, scroll divider and BCD score
// with speed-up every 100 points.
module game_sequencer
  import game_pkg::*;
#(
  parameter int unsigned TICK_DIV   = DefTickDiv,
  parameter int unsigned MIN_DIV    = DefMinDiv,
  parameter int unsigned SPEED_STEP = DefSpeedStep,
  parameter int unsigned JUMP_TICKS = DefJumpTicks
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        btn_start,
  input  logic        btn_jump,
  input  logic        btn_duck,
  input  logic        col_in,
  output logic        up,
  output logic        down,
  output logic        scroll_tick,
  output logic        game_run,
  output logic        game_over,
  output logic [15:0] score
);

  localparam int unsigned PeriodW = $clog2(TICK_DIV + 1);
  localparam int unsigned StepSat = (SPEED_STEP > TICK_DIV) ? TICK_DIV : SPEED_STEP;
  localparam logic [PeriodW-1:0] TickDivP = PeriodW'(TICK_DIV);
  localparam logic [PeriodW-1:0] MinDivP  = PeriodW'(MIN_DIV);
  localparam logic [PeriodW-1:0] StepP    = PeriodW'(StepSat);
  localparam int unsigned AirW = $clog2(JUMP_TICKS + 1);
  localparam logic [AirW-1:0] AirLast = AirW'(JUMP_TICKS - 1);

  main_state_e main_q, main_d;
  pose_e pose_q, pose_d;
  logic [AirW-1:0] air_cnt_q, air_cnt_d;
  logic [PeriodW-1:0] period_q, period_d;
  logic [15:0] score_q, score_d;
  logic start_prev_q, start_edge_q, jump_prev_q, jump_edge_q;
  logic up_q, down_q, tick_q;
  logic run, due, enter_run;

  assign run = (main_q == StRun);

  tick_divider #(
    .Width (PeriodW)
  ) u_div (
    .clk    (clk),
    .rst    (rst),
    .en     (run),
    .clr    (col_in),
    .period (period_q),
    .tick   (due)
  );

  always_comb begin
    main_d    = main_q;
    enter_run = 1'b0;
    unique case (main_q)
      StIdle, StOver: begin
        if (start_edge_q) begin
          main_d    = StRun;
          enter_run = 1'b1;
        end
      end
      StRun:   if (col_in) main_d = StOver;
      default: main_d = StIdle;
    endcase
  end

  always_comb begin
    score_d  = score_q;
    period_d = period_q;
    if (enter_run) begin
      score_d  = '0;
      period_d = TickDivP;
    end else if (due) begin
      score_d = bcd_inc(score_q);
      if (score_q[7:0] == 8'h99) begin
        period_d = (period_q - MinDivP >= StepP) ? period_q - StepP : MinDivP;
      end
    end
  end

  // Pose advances on the registered tick, so airtime spans JUMP_TICKS visible pulses.
  always_comb begin
    pose_d    = pose_q;
    air_cnt_d = air_cnt_q;
    if (!run || col_in) begin
      pose_d    = PoseGround;
      air_cnt_d = '0;
    end else begin
      unique case (pose_q)
        PoseGround: begin
          if (jump_edge_q) begin
            pose_d    = PoseAir;
            air_cnt_d = '0;
          end else if (btn_duck) begin
            pose_d = PoseDuck;
          end
        end
        PoseDuck: begin
          if (jump_edge_q) begin
            pose_d    = PoseAir;
            air_cnt_d = '0;
          end else if (!btn_duck) begin
            pose_d = PoseGround;
          end
        end
        PoseAir: begin
          if (tick_q) begin
            if (air_cnt_q == AirLast) pose_d = PoseLand;
            else air_cnt_d = air_cnt_q + AirW'(1);
          end
        end
        PoseLand: if (tick_q) pose_d = PoseGround;
        default:  pose_d = PoseGround;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      main_q       <= StIdle;
      pose_q       <= PoseGround;
      air_cnt_q    <= '0;
      period_q     <= TickDivP;
      score_q      <= '0;
      start_prev_q <= 1'b0;
      start_edge_q <= 1'b0;
      jump_prev_q  <= 1'b0;
      jump_edge_q  <= 1'b0;
      up_q         <= 1'b0;
      down_q       <= 1'b0;
      tick_q       <= 1'b0;
    end else begin
      main_q       <= main_d;
      pose_q       <= pose_d;
      air_cnt_q    <= air_cnt_d;
      period_q     <= period_d;
      score_q      <= score_d;
      start_prev_q <= btn_start;
      start_edge_q <= btn_start & ~start_prev_q;
      jump_prev_q  <= btn_jump;
      jump_edge_q  <= btn_jump & ~jump_prev_q;
      up_q         <= (pose_d == PoseAir);
      down_q       <= (pose_d == PoseDuck);
      tick_q       <= due;
    end
  end

  assign up          = up_q;
  assign down        = down_q;
  assign scroll_tick = tick_q;
  assign game_run    = run;
  assign game_over   = (main_q == StOver);
  assign score       = score_q;

endmodule
